// File: rtl/fpadd_seq.sv
// rtl/fpadd_seq.sv - FPADD initiator: operand handshake, two-beat load, result capture.
// Optional FPADD_SEQ_TIMEOUT_EN aborts a stuck WAIT with a NaN/error result and re-drains.
module fpadd_seq #(
  parameter int DRAIN_CYC   = 64,
  parameter int TIMEOUT_CYC = 63
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] OPA,
  input  logic [15:0] OPB,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] RESULT,
  output logic        RES_OVF,
  output logic        RES_UNF,
  output logic        RES_ERR,
  output logic        FP_ST,
  output logic [15:0] FP_IN,
  input  logic        FP_DONE,
  input  logic [15:0] FP_SUM,
  input  logic        FP_OVF,
  input  logic        FP_UNF
);

  localparam int CNT_MAX = (DRAIN_CYC > TIMEOUT_CYC + 1) ? DRAIN_CYC : TIMEOUT_CYC + 1;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [2:0] S_DRAIN = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_LDA   = 3'd2;
  localparam logic [2:0] S_LDB   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          fp_st_q, fp_st_d;
  logic [15:0]   fp_in_q, fp_in_d;
  logic [15:0]   opb_q, opb_d;
  logic [15:0]   result_q, result_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
`ifdef FPADD_SEQ_TIMEOUT_EN
  logic          err_q, err_d;
  assign RES_ERR = err_q;
`else
  assign RES_ERR = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    fp_st_d     = fp_st_q;
    fp_in_d     = fp_in_q;
    opb_d       = opb_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
`ifdef FPADD_SEQ_TIMEOUT_EN
    err_d       = err_q;
`endif
    case (state_q)
      S_DRAIN: begin
        // FPADD may still be finishing an op from before reset; let it run out
        fp_st_d = 1'b0;
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (IN_VALID && in_ready_q) begin
          opb_d      = OPB;
          in_ready_d = 1'b0;
          fp_st_d    = 1'b1;
          fp_in_d    = OPA;
          state_d    = S_LDA;
        end
      end
      S_LDA: begin
        fp_st_d = 1'b0;
        fp_in_d = opb_q;
        state_d = S_LDB;
      end
      S_LDB: begin
        fp_in_d = '0;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (FP_DONE) begin
          result_d    = FP_SUM;
          ovf_d       = FP_OVF;
          unf_d       = FP_UNF;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
`ifdef FPADD_SEQ_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT_CYC)) begin
          result_d    = 16'h7E00;
          ovf_d       = 1'b0;
          unf_d       = 1'b0;
          err_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      S_OUT: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
`ifdef FPADD_SEQ_TIMEOUT_EN
          // an aborted FPADD is in an unknown state, so drain it before reuse
          if (err_q) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            in_ready_d = 1'b1;
            state_d    = S_IDLE;
          end
`else
          in_ready_d = 1'b1;
          state_d    = S_IDLE;
`endif
        end
      end
      default: begin
        state_d = S_DRAIN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_DRAIN;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      fp_st_q     <= 1'b0;
      fp_in_q     <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
`ifdef FPADD_SEQ_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      fp_st_q     <= fp_st_d;
      fp_in_q     <= fp_in_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
`ifdef FPADD_SEQ_TIMEOUT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign FP_ST     = fp_st_q;
  assign FP_IN     = fp_in_q;
  assign RESULT    = result_q;
  assign RES_OVF   = ovf_q;
  assign RES_UNF   = unf_q;

endmodule

// File: tb/tb_fpadd_seq.sv
// tb/tb_fpadd_seq.sv - scoreboard bench for fpadd_seq with a behavioural FPADD stub.
// Honours FPADD_SEQ_TIMEOUT_EN to pick the stuck-FPADD expectation.
module tb_fpadd_seq;
  localparam int DRAIN_CYC   = 64;
  localparam int TIMEOUT_CYC = 63;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] OPA = '0, OPB = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [15:0] RESULT;
  logic        RES_OVF, RES_UNF, RES_ERR;
  logic        FP_ST;
  logic [15:0] FP_IN;
  logic        FP_DONE = 1'b0;
  logic [15:0] FP_SUM = '0;
  logic        FP_OVF = 1'b0, FP_UNF = 1'b0;

  fpadd_seq #(.DRAIN_CYC(DRAIN_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK(CLK), .RSTn(RSTn), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPA(OPA), .OPB(OPB), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RESULT(RESULT), .RES_OVF(RES_OVF), .RES_UNF(RES_UNF), .RES_ERR(RES_ERR),
    .FP_ST(FP_ST), .FP_IN(FP_IN), .FP_DONE(FP_DONE), .FP_SUM(FP_SUM),
    .FP_OVF(FP_OVF), .FP_UNF(FP_UNF)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference half-precision arithmetic via real numbers (truncating rounding)
  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real m;
    if (e == 0) m = real'(h[9:0]) * pow2(-24);
    else m = (1.0 + real'(h[9:0]) / 1024.0) * pow2(e - 15);
    return h[15] ? -m : m;
  endfunction

  // returns {unf, ovf, sum}
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    real  x = h2r(a) + h2r(b);
    logic s = (x < 0.0);
    real  m = s ? -x : x;
    int   e = 15;
    int   f;
    if (m == 0.0) return 18'h0;
    if (m >= 65536.0) return {1'b0, 1'b1, s, 5'h1f, 10'h0};
    if (m < pow2(-14)) return {1'b1, 1'b0, s, 15'h0};
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    f = int'($floor((m - 1.0) * 1024.0));
    return {2'b00, s, 5'(e), 10'(f)};
  endfunction

  function automatic logic [15:0] rand_h();
    return {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
  endfunction

  // FPADD stub: samples A on St, B next cycle, done after stub_lat cycles; never reset
  logic [15:0] stub_a = '0, stub_b = '0;
  bit          stub_phb = 0, stub_busy = 0, stub_hang = 0;
  int          stub_cnt = 0;
  int          stub_lat = 4;
  always @(posedge CLK) begin
    if (FP_ST) begin
      stub_a <= FP_IN; stub_phb <= 1; stub_busy <= 0; FP_DONE <= 0;
    end else if (stub_phb) begin
      stub_b <= FP_IN; stub_phb <= 0; stub_busy <= !stub_hang; stub_cnt <= stub_lat;
    end else if (stub_busy) begin
      if (stub_cnt <= 1) begin
        {FP_UNF, FP_OVF, FP_SUM} <= ref_add(stub_a, stub_b);
        FP_DONE   <= 1;
        stub_busy <= 0;
      end else stub_cnt <= stub_cnt - 1;
    end
  end

  // Consumer: random backpressure unless forced
  bit rdy_force = 1, rdy_val = 1;
  initial forever begin
    @(posedge CLK); #2;
    OUT_READY = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
  end

  // Scoreboard monitor: {err, unf, ovf, sum}
  logic [18:0] exp_q[$];
  logic [15:0] last_res = '0;
  logic        last_ovf = 0, last_unf = 0, last_err = 0;
  always @(negedge CLK) begin
    if (RSTn && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) fail_now("sb_unexpected_output");
      else begin
        chk("sb_result", 32'(RESULT), 32'(exp_q[0][15:0]));
        chk("sb_ovf", 32'(RES_OVF), 32'(exp_q[0][16]));
        chk("sb_unf", 32'(RES_UNF), 32'(exp_q[0][17]));
        chk("sb_err", 32'(RES_ERR), 32'(exp_q[0][18]));
        void'(exp_q.pop_front());
      end
      last_res <= RESULT; last_ovf <= RES_OVF; last_unf <= RES_UNF; last_err <= RES_ERR;
    end
  end

  // FPADD load monitor: St one cycle with A, then B on the next cycle
  logic [15:0] cur_a = '0, cur_b = '0;
  bit          fp_prev = 0;
  always @(negedge CLK) begin
    if (fp_prev) begin
      chk("fp_st_one_cycle", 32'(FP_ST), 32'd0);
      chk("fp_in_b", 32'(FP_IN), 32'(cur_b));
    end
    if (FP_ST) chk("fp_in_a", 32'(FP_IN), 32'(cur_a));
    fp_prev <= FP_ST;
  end

  task automatic issue_op(input logic [15:0] a, input logic [15:0] b, input int lat, input bit push);
    int t = 0;
    @(negedge CLK);
    while (!IN_READY && t < 3000) begin @(negedge CLK); t++; end
    if (!IN_READY) begin fail_now("in_ready_wait"); return; end
    if (push) exp_q.push_back({1'b0, ref_add(a, b)});
    cur_a = a; cur_b = b; stub_lat = lat;
    IN_VALID = 1; OPA = a; OPB = b;
    @(negedge CLK);
    // junk offered while busy must be ignored
    IN_VALID = 1'($urandom); OPA = 16'($urandom); OPB = 16'($urandom);
    @(negedge CLK);
    IN_VALID = 0;
  endtask

  task automatic wait_out();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge CLK); t++; end
    if (exp_q.size() != 0) fail_now("out_wait");
    @(negedge CLK);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int lat);
    issue_op(a, b, lat, 1);
    wait_out();
  endtask

  task automatic release_and_drain();
    int k_found = 0;
    bit st_seen = 0;
    @(negedge CLK);
    RSTn = 1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge CLK); #1;
      if (FP_ST) st_seen = 1;
      if (IN_READY) begin k_found = k; break; end
    end
    chk("drain_len", 32'(k_found), 32'(DRAIN_CYC));
    chk("fp_st_in_drain", 32'(st_seen), 32'd0);
    @(negedge CLK);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", 32'(IN_READY), 32'd0);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_fp_st", 32'(FP_ST), 32'd0);
    chk("rst_fp_in", 32'(FP_IN), 32'd0);
    chk("rst_result", 32'(RESULT), 32'd0);
    chk("rst_flags", 32'({RES_OVF, RES_UNF, RES_ERR}), 32'd0);
  endtask

  initial begin
    int t;
    bit seen;
    repeat (3) @(negedge CLK);
    chk_reset_vals();
    release_and_drain();

    do_op(16'h3C00, 16'h3C00, 3);
    chk("one_plus_one", 32'({last_res, last_ovf, last_unf}), 32'({16'h4000, 2'b00}));
    do_op(16'h3C00, 16'hBC00, 2);
    chk("one_minus_one", 32'({last_res, last_ovf}), 32'({16'h0000, 1'b0}));
    do_op(16'h3C00, 16'h4000, 1);
    chk("one_plus_two", 32'(last_res), 32'h4200);

    rdy_force = 0;
    for (int i = 0; i < 20; i++) begin
      do_op(rand_h(), rand_h(), int'($urandom_range(1, 20)));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    rdy_force = 1; rdy_val = 0;
    repeat (2) @(negedge CLK);
    issue_op(16'h7800, 16'h7800, 2, 1);
    t = 0;
    while (!OUT_VALID && t < 200) begin @(negedge CLK); t++; end
    if (!OUT_VALID) fail_now("ovf_out_valid");
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(OUT_VALID), 32'd1);
      chk("hold_result", 32'({RESULT, RES_OVF, RES_UNF}), 32'({16'h7C00, 2'b10}));
      chk("hold_in_ready", 32'(IN_READY), 32'd0);
      @(negedge CLK);
    end
    rdy_val = 1;
    wait_out();
    chk("ovf_flag", 32'(last_ovf), 32'd1);

    issue_op(16'h3C00, 16'h4000, 40, 1);
    repeat (5) @(negedge CLK);
    RSTn = 0;
    exp_q.delete();
    #1;
    chk_reset_vals();
    release_and_drain();
    do_op(16'h3C00, 16'h4000, 3);
    chk("post_reset_sum", 32'(last_res), 32'h4200);

    stub_hang = 1;
`ifdef FPADD_SEQ_TIMEOUT_EN
    exp_q.push_back({1'b1, 2'b00, 16'h7E00});
    issue_op(16'h3C00, 16'h3C00, 1, 0);
    wait_out();
    chk("timeout_result", 32'({last_res, last_err}), 32'({16'h7E00, 1'b1}));
    stub_hang = 0;
    repeat (30) @(negedge CLK);
    chk("timeout_redrain", 32'(IN_READY), 32'd0);
    do_op(16'h3C00, 16'h3C00, 2);
    chk("after_timeout_sum", 32'({last_res, last_err}), 32'({16'h4000, 1'b0}));
`else
    issue_op(16'h3C00, 16'h3C00, 1, 0);
    seen = 0;
    repeat (150) begin @(negedge CLK); if (OUT_VALID) seen = 1; end
    chk("no_timeout_wait", 32'(seen), 32'd0);
    RSTn = 0;
    stub_hang = 0;
    repeat (2) @(negedge CLK);
    release_and_drain();
    do_op(16'h3C00, 16'h3C00, 2);
    chk("after_hang_sum", 32'(last_res), 32'h4000);
`endif

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
